// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects the three
// panel buttons. Left and right auto-repeat while they are held, and they
// never pulse in the same cycle.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic left,
    input  logic right,
    input  logic put,
    output logic left_pulse,
    output logic right_pulse,
    output logic put_pulse
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAXV = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W    = $clog2(RPT_MAXV + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
    localparam logic [RPT_W-1:0] RPT_SAT    = RPT_W'(RPT_MAXV);
    localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    // Channel index: 0 = left, 1 = right, 2 = put
    logic [2:0]       w_raw;
    logic [2:0]       r_s1;
    logic [2:0]       r_s2;
    logic [2:0]       r_stable;
    logic [DB_W-1:0]  r_dbCnt [3];
    logic [2:0]       w_rise;

    state_t           r_state      [2];
    state_t           w_stateNext  [2];
    logic [RPT_W-1:0] r_rptCnt     [2];
    logic [RPT_W-1:0] w_rptCntNext [2];
    logic [1:0]       w_cand;
    logic             w_both;

    logic r_leftPulse;
    logic r_rightPulse;
    logic r_putPulse;

    assign w_raw  = {put, right, left};
    assign w_both = r_stable[0] & r_stable[1];

    // Two-flop synchroniser plus debounce: stable only follows s2 after a full unbroken mismatch run
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_stable <= '0;
            for (int i = 0; i < 3; i++) begin
                r_dbCnt[i] <= '0;
            end
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            for (int i = 0; i < 3; i++) begin
                if (r_s2[i] == r_stable[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (r_dbCnt[i] == DB_LAST) begin
                    r_stable[i] <= r_s2[i];
                    r_dbCnt[i]  <= '0;
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + DB_ONE;
                end
            end
        end
    end

    // A press is the cycle in which stable is about to be accepted as 1
    always_comb begin
        w_rise = '0;
        for (int i = 0; i < 3; i++) begin
            w_rise[i] = r_s2[i] & ~r_stable[i] & (r_dbCnt[i] == DB_LAST);
        end
    end

    // Repeat FSM state and counter registers for left and right
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i]  <= IDLE;
                r_rptCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_state[i]  <= w_stateNext[i];
                r_rptCnt[i] <= w_rptCntNext[i];
            end
        end
    end

    // Next-state and pulse candidates; holding both buttons parks both FSMs in DELAY with cleared counters
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < 2; i++) begin
            w_stateNext[i]  = r_state[i];
            w_rptCntNext[i] = (r_rptCnt[i] == RPT_SAT) ? r_rptCnt[i] : r_rptCnt[i] + RPT_ONE;
            if (w_rise[i]) begin
                w_cand[i]       = 1'b1;
                w_stateNext[i]  = REPEAT_EN ? DELAY : IDLE;
                w_rptCntNext[i] = '0;
            end else if (!r_stable[i] || !REPEAT_EN) begin
                w_stateNext[i]  = IDLE;
                w_rptCntNext[i] = '0;
            end else if (w_both) begin
                w_stateNext[i]  = DELAY;
                w_rptCntNext[i] = '0;
            end else begin
                case (r_state[i])
                    DELAY: begin
                        if (r_rptCnt[i] == DELAY_LAST) begin
                            w_cand[i]       = 1'b1;
                            w_stateNext[i]  = REPEAT;
                            w_rptCntNext[i] = '0;
                        end
                    end
                    REPEAT: begin
                        if (r_rptCnt[i] == RATE_LAST) begin
                            w_cand[i]       = 1'b1;
                            w_rptCntNext[i] = '0;
                        end
                    end
                    default: begin
                        w_stateNext[i]  = IDLE;
                        w_rptCntNext[i] = '0;
                    end
                endcase
            end
        end
    end

    // Registered outputs; coincident left/right candidates cancel each other
    always_ff @(posedge clk) begin
        if (rst) begin
            r_leftPulse  <= 1'b0;
            r_rightPulse <= 1'b0;
            r_putPulse   <= 1'b0;
        end else begin
            r_leftPulse  <= w_cand[0] & ~w_cand[1];
            r_rightPulse <= w_cand[1] & ~w_cand[0];
            r_putPulse   <= w_rise[2];
        end
    end

    assign left_pulse  = r_leftPulse;
    assign right_pulse = r_rightPulse;
    assign put_pulse   = r_putPulse;

endmodule
